binary_stream: RTL and testbench
================================

Name: binary_stream

Overview:
- Streaming, parametrised successor to the combinational binariser stage in the BNN-VAD datapath.
- Takes WIDTH signed lanes per beat and compares each lane against a per-lane programmable threshold, with an optional per-lane sign flip (folded batch-norm).
- Emits +1/-1 per lane as TARGET_DEPTH-bit two's complement, or as a packed 1-bit vector.
- Sits between the MAC/accumulator output and the next binary layer, with a valid/ready handshake and one register stage.

Parameters:
- DEPTH, 32, bit width of each signed input lane and of each threshold.
- TARGET_DEPTH, 2, bit width of each output lane when PACKED=0; must be >= 2.
- WIDTH, 3, number of lanes per beat; must be >= 1.
- PACKED, 0, 1 = output 1 bit per lane (1 means +1, 0 means -1), so lane width is 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH*DEPTH  flattened signed lanes; lane i is bits [i*DEPTH +: DEPTH].
- in_last  input  1  frame-end marker; carried through with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH*OW  flattened lanes; OW = PACKED ? 1 : TARGET_DEPTH.
- out_last  output  1  registered copy of in_last.
- cfg_we  input  1  threshold/flip write strobe.
- cfg_addr  input  max(1,$clog2(WIDTH))  lane index to write.
- cfg_thresh  input  DEPTH  signed threshold to store.
- cfg_flip  input  1  flip bit to store.

Behaviour:
- Reset (async assert, sync-released by the system): out_valid=0, out_data=0, out_last=0, all thresholds=0, all flips=0.
- Reset mid-operation discards any held beat.
- With reset values the block reproduces the legacy binariser: data>=0 gives +1, otherwise -1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output register, no skid).
  - Accept occurs when in_valid && in_ready.
  - On accept the registers load out_data and out_last, and out_valid=1 on the next cycle. Latency is 1 cycle.
  - If out_valid && out_ready and there is no accept, out_valid goes to 0.
  - Accept and drain in the same cycle gives back-to-back throughput of one beat per cycle.
  - While out_valid && !out_ready, out_data and out_last hold stable and in_ready=0.
- Lane function (signed compare, full DEPTH bits):
  - pos = (lane >= thresh[i]) XOR flip[i].
  - The equal case therefore gives +1 when flip=0 and -1 when flip=1.
  - PACKED=0: +1 is encoded as 1 zero-extended, -1 as all ones (sign-extended).
  - PACKED=1: the output bit equals pos.
- cfg_addr >= WIDTH: the write is ignored.
- Write while streaming:
  - The register updates at the clock edge.
  - A beat accepted in the same cycle as cfg_we uses the old value.
  - Beats accepted later use the new value.
- Threshold writes are accepted regardless of handshake state; cfg has no ready.
- in_data is ignored when in_valid=0. The output is never updated without an accept.
- Extreme values: thresh = most-negative gives always +1 (flip=0); lane = most-positive is always >= thresh. No overflow is possible because the compare is direct, not a subtraction.

Optional Feature:
- Macro BINARY_STREAM_POPCOUNT_EN.
- When defined:
  - Extra output out_popcnt, width $clog2(WIDTH+1), giving the number of +1 lanes in the current output beat.
  - It is registered alongside out_data, has the same valid/hold rules, and resets to 0.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset default (WIDTH=3, DEPTH=32, PACKED=0): lanes {5, 0, -1}, out_ready=1 -> one cycle later out_valid=1 and lanes {01, 01, 11}.
- Programmed thresholds: write lane0 thresh=10 flip=0 and lane1 thresh=-4 flip=1; send {10, -4, 7} -> {+1, -1, +1}. Send {9, -5, -8} -> {-1, +1, -1}.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data held; raising out_ready -> one beat per cycle thereafter with no loss or duplication, checked on a 16-beat sequence with in_last on beat 15.
- Config collision: cfg_we for lane2 thresh=100 in the same cycle a beat with lane2=50 is accepted -> that beat gives +1; the next beat with lane2=50 gives -1. A write with cfg_addr=3 changes nothing.
- Async reset: assert rst_n=0 mid-stream while out_valid=1 -> out_valid and out_data drop immediately, thresholds return to 0, in_ready=1 after release.
- PACKED=1 with BINARY_STREAM_POPCOUNT_EN, WIDTH=8: lanes {1,-1,1,1,-1,-1,1,0} at default thresholds -> out_data=8'b11001101 (lane0 in the LSB), out_popcnt=5.

Source files
------------

// File: rtl/binary_stream.sv
// Streaming per-lane threshold binariser with valid/ready handshake and one output register.
// Optional out_popcnt port (count of +1 lanes) enabled by BINARY_STREAM_POPCOUNT_EN.
module binary_stream #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned TARGET_DEPTH = 2,
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned PACKED       = 0,
  localparam int unsigned OW = (PACKED != 0) ? 1 : TARGET_DEPTH,
  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*OW-1:0]   out_data,
  output logic                  out_last,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [DEPTH-1:0]      cfg_thresh,
  input  logic                  cfg_flip
`ifdef BINARY_STREAM_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

  logic signed [DEPTH-1:0] thresh [WIDTH];
  logic [WIDTH-1:0]        flip;
  logic [WIDTH-1:0]        pos_c;
  logic [WIDTH*OW-1:0]     lanes_c;
  logic                    accept_c;

  // Single output register without skid: ready whenever the slot is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Direct signed compare, so extreme operands cannot overflow.
  always_comb begin
    pos_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos_c[i] = ($signed(in_data[i*DEPTH +: DEPTH]) >= thresh[i]) ^ flip[i];
    end
  end

  // +1 is 1 zero-extended, -1 is all ones; packed mode keeps just the sign decision.
  always_comb begin
    lanes_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (PACKED != 0) begin
        lanes_c[i*OW +: OW] = OW'(pos_c[i]);
      end else begin
        lanes_c[i*OW +: OW] = pos_c[i] ? OW'(1) : {OW{1'b1}};
      end
    end
  end

  // Out-of-range addresses match no lane and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        thresh[i] <= '0;
      end
      flip <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cfg_addr == AW'(i)) begin
          thresh[i] <= cfg_thresh;
          flip[i]   <= cfg_flip;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= lanes_c;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BINARY_STREAM_POPCOUNT_EN
  localparam int unsigned PW = $clog2(WIDTH + 1);

  logic [PW-1:0] popcnt_c;

  always_comb begin
    popcnt_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt_c = popcnt_c + PW'(pos_c[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_popcnt <= '0;
    end else if (accept_c) begin
      out_popcnt <= popcnt_c;
    end
  end
`endif

endmodule

// File: tb/tb_binary_stream.sv
// Randomised and directed checks of binary_stream against a cycle-level behavioural model.
module tb_binary_stream;
  localparam int unsigned D   = 32;
  localparam int unsigned W   = 3;
  localparam int unsigned OW  = 2;
  localparam int unsigned PKW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [W*D-1:0]  in_data;
  logic [W*OW-1:0] out_data;
  logic            cfg_we, cfg_flip;
  logic [1:0]      cfg_addr;
  logic [D-1:0]    cfg_thresh;

  logic             pk_in_valid, pk_in_ready, pk_in_last, pk_out_valid, pk_out_ready, pk_out_last;
  logic [PKW*D-1:0] pk_in_data;
  logic [PKW-1:0]   pk_out_data;
  logic             pk_cfg_we, pk_cfg_flip;
  logic [2:0]       pk_cfg_addr;
  logic [D-1:0]     pk_cfg_thresh;
`ifdef BINARY_STREAM_POPCOUNT_EN
  logic [1:0] popcnt;
  logic [3:0] pk_popcnt;
`endif

  binary_stream #(.DEPTH(D), .TARGET_DEPTH(2), .WIDTH(W), .PACKED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_thresh(cfg_thresh),
    .cfg_flip(cfg_flip)
`ifdef BINARY_STREAM_POPCOUNT_EN
    , .out_popcnt(popcnt)
`endif
  );

  binary_stream #(.DEPTH(D), .TARGET_DEPTH(2), .WIDTH(PKW), .PACKED(1)) u_pk (
    .clk(clk), .rst_n(rst_n), .in_valid(pk_in_valid), .in_ready(pk_in_ready), .in_data(pk_in_data),
    .in_last(pk_in_last), .out_valid(pk_out_valid), .out_ready(pk_out_ready), .out_data(pk_out_data),
    .out_last(pk_out_last), .cfg_we(pk_cfg_we), .cfg_addr(pk_cfg_addr), .cfg_thresh(pk_cfg_thresh),
    .cfg_flip(pk_cfg_flip)
`ifdef BINARY_STREAM_POPCOUNT_EN
    , .out_popcnt(pk_popcnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  int         m_th [W];
  bit         m_fl [W];
  bit         m_v, m_l;
  logic [5:0] m_d;
  int         m_p;
  int         n_pop, n_last_pop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input int d, input int t, input bit f);
    bit pos;
    pos = (d >= t) != f;
    return pos ? 2'b01 : 2'b11;
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 5))
      0:       return int'(32'h8000_0000);
      1:       return int'(32'h7fff_ffff);
      2, 3:    return int'($urandom_range(0, 16)) - 8;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic set_lanes(input int a, input int b, input int c);
    in_data = {c, b, a};
  endtask

  task automatic model_reset();
    m_v = 0; m_l = 0; m_d = '0; m_p = 0;
    for (int i = 0; i < W; i++) begin
      m_th[i] = 0;
      m_fl[i] = 0;
    end
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare at the falling edge.
  task automatic cycle();
    bit         acc;
    logic [5:0] nd;
    int         np;
    int         lane;
    acc = in_valid && (!m_v || out_ready);
    nd = '0;
    np = 0;
    for (int i = 0; i < W; i++) begin
      lane = in_data[i*D +: D];
      nd[i*2 +: 2] = enc(lane, m_th[i], m_fl[i]);
      if (nd[i*2 +: 2] == 2'b01) np++;
    end
    @(posedge clk);
    if (m_v && out_ready) begin
      n_pop++;
      if (m_l) n_last_pop++;
    end
    if (acc) begin
      m_d = nd; m_l = in_last; m_v = 1; m_p = np;
    end else if (out_ready) begin
      m_v = 0;
    end
    if (cfg_we && cfg_addr < W) begin
      m_th[cfg_addr] = int'(cfg_thresh);
      m_fl[cfg_addr] = cfg_flip;
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_v));
    chk("in_ready", 64'(in_ready), 64'(!m_v || out_ready));
    chk("out_data", 64'(out_data), 64'(m_d));
    chk("out_last", 64'(out_last), 64'(m_l));
`ifdef BINARY_STREAM_POPCOUNT_EN
    chk("out_popcnt", 64'(popcnt), 64'(m_p));
`endif
  endtask

  task automatic pk_beat(input int lanes [PKW], output logic [PKW-1:0] bits, output int cnt);
    cnt = 0;
    for (int i = 0; i < PKW; i++) begin
      pk_in_data[i*D +: D] = lanes[i];
      bits[i] = lanes[i] >= 0;
      if (bits[i]) cnt++;
    end
  endtask

  initial begin
    int             pk_lanes [PKW];
    logic [PKW-1:0] pk_exp;
    int             pk_cnt;
    int             seq [16][W];
    int             idx, cyc;
    bit             acc;

    in_valid = 0; in_last = 0; out_ready = 0; in_data = '0;
    cfg_we = 0; cfg_addr = '0; cfg_thresh = '0; cfg_flip = 0;
    pk_in_valid = 0; pk_in_last = 0; pk_out_ready = 0; pk_in_data = '0;
    pk_cfg_we = 0; pk_cfg_addr = '0; pk_cfg_thresh = '0; pk_cfg_flip = 0;
    model_reset();
    n_pop = 0; n_last_pop = 0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_pk_out_data", 64'(pk_out_data), 64'(0));
    rst_n = 1;
    @(negedge clk);

    // Packed instance: directed beat then random beats at full rate
    pk_lanes = '{1, -1, 1, 1, -1, -1, 1, 0};
    pk_beat(pk_lanes, pk_exp, pk_cnt);
    pk_in_valid = 1; pk_out_ready = 1;
    @(negedge clk);
    chk("pk_valid", 64'(pk_out_valid), 64'(1));
    chk("pk_data_dir", 64'(pk_out_data), 64'(8'b1100_1101));
`ifdef BINARY_STREAM_POPCOUNT_EN
    chk("pk_popcnt_dir", 64'(pk_popcnt), 64'(5));
`endif
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < PKW; i++) pk_lanes[i] = rnd_val();
      pk_beat(pk_lanes, pk_exp, pk_cnt);
      @(negedge clk);
      chk("pk_data", 64'(pk_out_data), 64'(pk_exp));
`ifdef BINARY_STREAM_POPCOUNT_EN
      chk("pk_popcnt", 64'(pk_popcnt), 64'(pk_cnt));
`endif
    end
    pk_out_ready = 0;
    for (int i = 0; i < PKW; i++) pk_in_data[i*D +: D] = ~pk_in_data[i*D +: D];
    @(negedge clk);
    chk("pk_hold_data", 64'(pk_out_data), 64'(pk_exp));
    chk("pk_hold_ready", 64'(pk_in_ready), 64'(0));
    pk_in_valid = 0; pk_out_ready = 1;
    @(negedge clk);
    chk("pk_drain", 64'(pk_out_valid), 64'(0));

    // Legacy behaviour at reset thresholds
    out_ready = 1; in_valid = 1;
    set_lanes(5, 0, -1);
    cycle();
    chk("legacy_lanes", 64'(out_data), 64'(6'b11_01_01));

    // Programmed thresholds
    in_valid = 0;
    cfg_we = 1; cfg_addr = 0; cfg_thresh = 32'd10; cfg_flip = 0;
    cycle();
    cfg_addr = 1; cfg_thresh = D'(-4); cfg_flip = 1;
    cycle();
    cfg_we = 0; in_valid = 1;
    set_lanes(10, -4, 7);
    cycle();
    chk("prog_a", 64'(out_data), 64'(6'b01_11_01));
    set_lanes(9, -5, -8);
    cycle();
    chk("prog_b", 64'(out_data), 64'(6'b11_01_11));
    in_valid = 0;
    cycle();

    // Backpressure then full-rate 16-beat sequence
    for (int b = 0; b < 16; b++)
      for (int i = 0; i < W; i++) seq[b][i] = rnd_val();
    n_pop = 0; n_last_pop = 0; idx = 0; cyc = 0;
    in_valid = 1;
    while (idx < 16 && cyc < 40) begin
      set_lanes(seq[idx][0], seq[idx][1], seq[idx][2]);
      in_last = (idx == 15);
      out_ready = (cyc >= 3);
      acc = !m_v || out_ready;
      cycle();
      if (cyc == 1 || cyc == 2) chk("bp_in_ready", 64'(in_ready), 64'(0));
      if (acc) idx++;
      cyc++;
    end
    chk("bp_beats_sent", 64'(idx), 64'(16));
    chk("bp_throughput", 64'(cyc), 64'(18));
    in_valid = 0; in_last = 0; out_ready = 1;
    cycle();
    chk("bp_beats_out", 64'(n_pop), 64'(16));
    chk("bp_last_count", 64'(n_last_pop), 64'(1));

    // Config write colliding with an accepted beat
    in_valid = 1;
    set_lanes(0, 0, 50);
    cfg_we = 1; cfg_addr = 2; cfg_thresh = 32'd100; cfg_flip = 0;
    cycle();
    chk("coll_old", 64'(out_data[5:4]), 64'(2'b01));
    cfg_we = 0;
    cycle();
    chk("coll_new", 64'(out_data[5:4]), 64'(2'b11));
    in_valid = 0;
    cfg_we = 1; cfg_addr = 3; cfg_thresh = D'(-1000); cfg_flip = 1;
    cycle();
    cfg_we = 0; in_valid = 1;
    cycle();
    chk("cfg_oob", 64'(out_data), 64'(6'b11_11_11));

    // Async reset while a beat is held
    out_ready = 0;
    cycle();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("arst_ready", 64'(in_ready), 64'(1));
    in_valid = 1; out_ready = 1;
    set_lanes(9, -5, -8);
    cycle();
    chk("arst_thresh", 64'(out_data), 64'(6'b11_11_01));

    // Extreme operands
    in_valid = 0;
    cfg_we = 1; cfg_addr = 0; cfg_thresh = 32'h8000_0000; cfg_flip = 0;
    cycle();
    cfg_addr = 1; cfg_thresh = 32'h7fff_ffff;
    cycle();
    cfg_we = 0; in_valid = 1;
    set_lanes(int'(32'h8000_0000), int'(32'h7fff_ffff), 0);
    cycle();
    chk("extremes", 64'(out_data), 64'(6'b01_01_01));

    // Random traffic with random config writes
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      set_lanes(rnd_val(), rnd_val(), rnd_val());
      in_last = $urandom_range(0, 1) == 1;
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_thresh = D'(rnd_val());
      cfg_flip = $urandom_range(0, 1) == 1;
      cycle();
    end
    in_valid = 0; cfg_we = 0; out_ready = 1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
